// File: rtl/awb_pkg.sv
// Shared widths, gain constants and controller state encoding for the
// grey-world auto-white-balance gain path.
package awb_pkg;

  localparam int unsigned AWB_SUM_W  = 29;
  localparam int unsigned AWB_FRAC   = 8;
  localparam int unsigned AWB_GAIN_W = 10;

  localparam logic [AWB_GAIN_W-1:0] GAIN_UNITY = AWB_GAIN_W'(1 << AWB_FRAC);
  localparam logic [AWB_GAIN_W-1:0] GAIN_SAT   = '1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DIV_R = 2'd1,
    ST_DIV_B = 2'd2,
    ST_DONE  = 2'd3
  } awb_state_e;

endpackage

// File: rtl/awb_serial_div.sv
// Fixed-latency restoring divider: one load/check cycle, Q_W iteration
// cycles, one result cycle. Zero divisor and overflow bypass the iterations.
module awb_serial_div
  import awb_pkg::*;
#(
  parameter int unsigned     DEN_W   = AWB_SUM_W,
  parameter int unsigned     SHIFT   = AWB_FRAC,
  parameter int unsigned     Q_W     = AWB_GAIN_W,
  parameter logic [Q_W-1:0]  Q_UNITY = GAIN_UNITY,
  parameter logic [Q_W-1:0]  Q_SAT   = GAIN_SAT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [DEN_W+SHIFT-1:0] numerator,
  input  logic [DEN_W-1:0]       denominator,
  output logic                   done,
  output logic [Q_W-1:0]         quotient
);

  localparam int unsigned CNT_W = $clog2(Q_W + 2);
  localparam int unsigned CMP_W = DEN_W + Q_W + 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DEN_W-1:0] rem_q, rem_d;
  logic [DEN_W-1:0] den_q, den_d;
  logic [Q_W-1:0]   nlo_q, nlo_d;
  logic [Q_W-1:0]   quo_q, quo_d;
  logic             bypass_q, bypass_d;
  logic             done_q, done_d;
  logic [DEN_W:0]   trial_c;

  // Remainder starts as numerator >> Q_W, which is already below the divisor
  // once overflow is excluded, so exactly Q_W quotient bits remain.
  always_comb begin
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    den_d    = den_q;
    nlo_d    = nlo_q;
    quo_d    = quo_q;
    bypass_d = bypass_q;
    done_d   = 1'b0;
    trial_c  = {rem_q, nlo_q[Q_W-1]};
    if (start) begin
      cnt_d    = CNT_W'(1);
      den_d    = denominator;
      nlo_d    = numerator[Q_W-1:0];
      rem_d    = DEN_W'(numerator >> Q_W);
      quo_d    = '0;
      bypass_d = 1'b0;
      if (denominator == '0) begin
        quo_d    = Q_UNITY;
        bypass_d = 1'b1;
      end else if (CMP_W'(numerator) >= (CMP_W'(denominator) << Q_W)) begin
        quo_d    = Q_SAT;
        bypass_d = 1'b1;
      end
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q + CNT_W'(1);
      if ((cnt_q <= CNT_W'(Q_W)) && !bypass_q) begin
        nlo_d = nlo_q << 1;
        if (trial_c >= {1'b0, den_q}) begin
          rem_d = DEN_W'(trial_c - {1'b0, den_q});
          quo_d = {quo_q[Q_W-2:0], 1'b1};
        end else begin
          rem_d = DEN_W'(trial_c);
          quo_d = {quo_q[Q_W-2:0], 1'b0};
        end
      end
      if (cnt_q == CNT_W'(Q_W))     done_d = 1'b1;
      if (cnt_q == CNT_W'(Q_W + 1)) cnt_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      rem_q    <= '0;
      den_q    <= '0;
      nlo_q    <= '0;
      quo_q    <= '0;
      bypass_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      den_q    <= den_d;
      nlo_q    <= nlo_d;
      quo_q    <= quo_d;
      bypass_q <= bypass_d;
      done_q   <= done_d;
    end
  end

  assign done     = done_q;
  assign quotient = quo_q;

endmodule

// File: rtl/awb_gain_ctrl.sv
// Grey-world AWB gain controller: computes G/R and G/B on a shared serial
// divider, shadows the results and commits them only at frame start.
module awb_gain_ctrl
  import awb_pkg::*;
#(
  parameter int unsigned SUM_W  = AWB_SUM_W,
  parameter int unsigned FRAC   = AWB_FRAC,
  parameter int unsigned GAIN_W = AWB_GAIN_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stats_valid,
  input  logic [SUM_W-1:0]  sum_r,
  input  logic [SUM_W-1:0]  sum_g,
  input  logic [SUM_W-1:0]  sum_b,
  input  logic              frame_start,
  input  logic              enable,
  output logic [GAIN_W-1:0] gain_r,
  output logic [GAIN_W-1:0] gain_g,
  output logic [GAIN_W-1:0] gain_b,
  output logic              gain_update,
  output logic              busy,
  output logic              overrun
);

  localparam int unsigned         NUM_W = SUM_W + FRAC;
  localparam logic [GAIN_W-1:0]   UNITY = GAIN_W'(1 << FRAC);
  localparam logic [GAIN_W-1:0]   SAT   = '1;

  awb_state_e        state_q, state_d;
  logic [SUM_W-1:0]  sum_r_q, sum_r_d, sum_g_q, sum_g_d, sum_b_q, sum_b_d;
  logic              div_start_q, div_start_d;
  logic [GAIN_W-1:0] quo_r_q, quo_r_d;
  logic [GAIN_W-1:0] pend_r_q, pend_r_d, pend_b_q, pend_b_d;
  logic              pend_valid_q, pend_valid_d;
  logic [GAIN_W-1:0] gain_r_q, gain_r_d, gain_b_q, gain_b_d;
  logic              gain_update_q, gain_update_d;
  logic              busy_q, busy_d;
  logic              overrun_q, overrun_d;
  logic [NUM_W-1:0]  div_num_c;
  logic [SUM_W-1:0]  div_den_c;
  logic              div_done;
  logic [GAIN_W-1:0] div_quot;

  assign div_num_c = NUM_W'(sum_g_q) << FRAC;
  assign div_den_c = (state_q == ST_DIV_B) ? sum_b_q : sum_r_q;

  awb_serial_div #(
    .DEN_W  (SUM_W),
    .SHIFT  (FRAC),
    .Q_W    (GAIN_W),
    .Q_UNITY(UNITY),
    .Q_SAT  (SAT)
  ) u_div (
    .clk        (clk),
    .rst        (rst),
    .start      (div_start_q),
    .numerator  (div_num_c),
    .denominator(div_den_c),
    .done       (div_done),
    .quotient   (div_quot)
  );

  // Sequencer, shadow registers and frame-start commit.
  always_comb begin
    state_d       = state_q;
    sum_r_d       = sum_r_q;
    sum_g_d       = sum_g_q;
    sum_b_d       = sum_b_q;
    div_start_d   = 1'b0;
    quo_r_d       = quo_r_q;
    pend_r_d      = pend_r_q;
    pend_b_d      = pend_b_q;
    pend_valid_d  = pend_valid_q;
    gain_r_d      = gain_r_q;
    gain_b_d      = gain_b_q;
    overrun_d     = overrun_q;

    unique case (state_q)
      ST_IDLE: begin
        if (stats_valid) begin
          sum_r_d     = sum_r;
          sum_g_d     = sum_g;
          sum_b_d     = sum_b;
          div_start_d = 1'b1;
          state_d     = ST_DIV_R;
        end
      end
      ST_DIV_R: begin
        if (div_done) begin
          quo_r_d     = div_quot;
          div_start_d = 1'b1;
          state_d     = ST_DIV_B;
        end
      end
      ST_DIV_B: begin
        if (div_done) state_d = ST_DONE;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    if (stats_valid && (state_q != ST_IDLE)) overrun_d = 1'b1;

    if (frame_start) begin
      if (!enable) begin
        gain_r_d = UNITY;
        gain_b_d = UNITY;
      end else if (pend_valid_q) begin
        gain_r_d     = pend_r_q;
        gain_b_d     = pend_b_q;
        pend_valid_d = 1'b0;
      end
    end

    // Divider still holds the blue quotient while in DONE.
    if (state_q == ST_DONE) begin
      pend_r_d     = quo_r_q;
      pend_b_d     = div_quot;
      pend_valid_d = 1'b1;
    end

    busy_d        = (state_d != ST_IDLE);
    gain_update_d = (gain_r_d != gain_r_q) || (gain_b_d != gain_b_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      sum_r_q       <= '0;
      sum_g_q       <= '0;
      sum_b_q       <= '0;
      div_start_q   <= 1'b0;
      quo_r_q       <= '0;
      pend_r_q      <= UNITY;
      pend_b_q      <= UNITY;
      pend_valid_q  <= 1'b0;
      gain_r_q      <= UNITY;
      gain_b_q      <= UNITY;
      gain_update_q <= 1'b0;
      busy_q        <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      sum_r_q       <= sum_r_d;
      sum_g_q       <= sum_g_d;
      sum_b_q       <= sum_b_d;
      div_start_q   <= div_start_d;
      quo_r_q       <= quo_r_d;
      pend_r_q      <= pend_r_d;
      pend_b_q      <= pend_b_d;
      pend_valid_q  <= pend_valid_d;
      gain_r_q      <= gain_r_d;
      gain_b_q      <= gain_b_d;
      gain_update_q <= gain_update_d;
      busy_q        <= busy_d;
      overrun_q     <= overrun_d;
    end
  end

  assign gain_r      = gain_r_q;
  assign gain_g      = UNITY;
  assign gain_b      = gain_b_q;
  assign gain_update = gain_update_q;
  assign busy        = busy_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_awb_gain_ctrl.sv
// Directed bench for awb_gain_ctrl: busy window, gain ratios, divider
// boundaries, commit collisions, enable override and mid-computation reset.
module tb_awb_gain_ctrl;
  import awb_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  stats_valid = 1'b0;
  logic                  frame_start = 1'b0;
  logic                  enable = 1'b1;
  logic [AWB_SUM_W-1:0]  sum_r = '0, sum_g = '0, sum_b = '0;
  logic [AWB_GAIN_W-1:0] gain_r, gain_g, gain_b;
  logic                  gain_update, busy, overrun;

  int checks = 0;
  int errors = 0;

  awb_gain_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .stats_valid(stats_valid),
    .sum_r      (sum_r),
    .sum_g      (sum_g),
    .sum_b      (sum_b),
    .frame_start(frame_start),
    .enable     (enable),
    .gain_r     (gain_r),
    .gain_g     (gain_g),
    .gain_b     (gain_b),
    .gain_update(gain_update),
    .busy       (busy),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Stats pulse in cycle 0; returns in cycle 1.
  task automatic send_stats(input int r, input int g, input int b);
    sum_r = AWB_SUM_W'(r);
    sum_g = AWB_SUM_W'(g);
    sum_b = AWB_SUM_W'(b);
    stats_valid = 1'b1;
    tick();
    stats_valid = 1'b0;
  endtask

  // Frame start in cycle t; returns in cycle t+1.
  task automatic frame_pulse();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick();
    checks++;
    if ({gain_r, gain_g, gain_b} !== {10'd256, 10'd256, 10'd256}) begin
      errors++;
      $display("FAIL reset_gains: got %0d/%0d/%0d want 256/256/256", gain_r, gain_g, gain_b);
    end
    checks++;
    if ({gain_update, busy, overrun} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: got upd=%b busy=%b ovr=%b want 0/0/0", gain_update, busy, overrun);
    end
  endtask

  task automatic test_ratio();
    send_stats(1000000, 2000000, 4000000);
    for (int c = 1; c <= 26; c++) begin
      checks++;
      if (busy !== (c <= 25)) begin
        errors++;
        $display("FAIL ratio_busy cycle %0d: got %b want %b", c, busy, (c <= 25));
      end
      if (c < 26) tick();
    end
    checks++;
    if ({gain_r, gain_b, gain_update} !== {10'd256, 10'd256, 1'b0}) begin
      errors++;
      $display("FAIL ratio_precommit: got %0d/%0d upd=%b want 256/256 upd=0", gain_r, gain_b, gain_update);
    end
    tick(4);
    frame_pulse();
    checks++;
    if ({gain_r, gain_g, gain_b, gain_update} !== {10'd512, 10'd256, 10'd128, 1'b1}) begin
      errors++;
      $display("FAIL ratio_commit: got %0d/%0d/%0d upd=%b want 512/256/128 upd=1", gain_r, gain_g, gain_b, gain_update);
    end
    tick();
    checks++;
    if (gain_update !== 1'b0) begin
      errors++;
      $display("FAIL ratio_update_pulse: got %b want 0", gain_update);
    end
  endtask

  task automatic test_unity();
    send_stats(1000000, 1000000, 1000000);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL unity_busy_c1: got %b want 1", busy);
    end
    tick(24);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL unity_busy_c25: got %b want 1", busy);
    end
    tick(5);
    frame_pulse();
    checks++;
    if ({gain_r, gain_g, gain_b, gain_update} !== {10'd256, 10'd256, 10'd256, 1'b1}) begin
      errors++;
      $display("FAIL unity_commit: got %0d/%0d/%0d upd=%b want 256/256/256 upd=1", gain_r, gain_g, gain_b, gain_update);
    end
  endtask

  task automatic test_boundary();
    send_stats(0, 1000000, 100);
    for (int c = 1; c <= 26; c++) begin
      checks++;
      if (busy !== (c <= 25)) begin
        errors++;
        $display("FAIL boundary_busy cycle %0d: got %b want %b", c, busy, (c <= 25));
      end
      if (c < 26) tick();
    end
    tick(4);
    frame_pulse();
    checks++;
    if ({gain_r, gain_b, gain_update} !== {10'd256, 10'd1023, 1'b1}) begin
      errors++;
      $display("FAIL boundary_commit: got %0d/%0d upd=%b want 256/1023 upd=1", gain_r, gain_b, gain_update);
    end
  endtask

  task automatic test_trunc();
    send_stats(1001, 4000, 3000);
    tick(29);
    frame_pulse();
    checks++;
    if ({gain_r, gain_b, gain_update} !== {10'd1022, 10'd341, 1'b1}) begin
      errors++;
      $display("FAIL trunc_commit: got %0d/%0d upd=%b want 1022/341 upd=1", gain_r, gain_b, gain_update);
    end
  endtask

  task automatic test_overrun();
    send_stats(1000000, 2000000, 4000000);
    tick(9);
    send_stats(7, 7, 7);
    checks++;
    if ({overrun, busy} !== 2'b11) begin
      errors++;
      $display("FAIL overrun_set: got ovr=%b busy=%b want 1/1", overrun, busy);
    end
    tick(9);
    frame_pulse();
    checks++;
    if ({gain_r, gain_b, gain_update} !== {10'd1022, 10'd341, 1'b0}) begin
      errors++;
      $display("FAIL overrun_fs20: got %0d/%0d upd=%b want 1022/341 upd=0", gain_r, gain_b, gain_update);
    end
    tick(4);
    frame_pulse();
    checks++;
    if ({gain_r, gain_b, gain_update, busy} !== {10'd1022, 10'd341, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL overrun_fs25: got %0d/%0d upd=%b busy=%b want 1022/341 upd=0 busy=0", gain_r, gain_b, gain_update, busy);
    end
    tick(4);
    frame_pulse();
    checks++;
    if ({gain_r, gain_b, gain_update, overrun} !== {10'd512, 10'd128, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL overrun_fs30: got %0d/%0d upd=%b ovr=%b want 512/128 upd=1 ovr=1", gain_r, gain_b, gain_update, overrun);
    end
  endtask

  task automatic test_enable();
    send_stats(1000000, 2000000, 4000000);
    tick(25);
    enable = 1'b0;
    frame_pulse();
    checks++;
    if ({gain_r, gain_g, gain_b, gain_update} !== {10'd256, 10'd256, 10'd256, 1'b1}) begin
      errors++;
      $display("FAIL enable_off: got %0d/%0d/%0d upd=%b want 256/256/256 upd=1", gain_r, gain_g, gain_b, gain_update);
    end
    enable = 1'b1;
    tick(2);
    frame_pulse();
    checks++;
    if ({gain_r, gain_b, gain_update} !== {10'd512, 10'd128, 1'b1}) begin
      errors++;
      $display("FAIL enable_on: got %0d/%0d upd=%b want 512/128 upd=1", gain_r, gain_b, gain_update);
    end
    tick();
    frame_pulse();
    checks++;
    if ({gain_r, gain_b, gain_update} !== {10'd512, 10'd128, 1'b0}) begin
      errors++;
      $display("FAIL enable_empty: got %0d/%0d upd=%b want 512/128 upd=0", gain_r, gain_b, gain_update);
    end
  endtask

  task automatic test_rst_mid();
    send_stats(1000000, 2000000, 4000000);
    tick(14);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({gain_r, gain_b, busy, overrun, gain_update} !== {10'd256, 10'd256, 3'b000}) begin
      errors++;
      $display("FAIL rst_mid_state: got %0d/%0d busy=%b ovr=%b upd=%b want 256/256 0/0/0", gain_r, gain_b, busy, overrun, gain_update);
    end
    tick(2);
    frame_pulse();
    checks++;
    if ({gain_r, gain_b, gain_update} !== {10'd256, 10'd256, 1'b0}) begin
      errors++;
      $display("FAIL rst_mid_fs: got %0d/%0d upd=%b want 256/256 upd=0", gain_r, gain_b, gain_update);
    end
    send_stats(1000000, 3000000, 2000000);
    tick(25);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_busy_end: got %b want 0", busy);
    end
    frame_pulse();
    checks++;
    if ({gain_r, gain_b, gain_update} !== {10'd768, 10'd384, 1'b1}) begin
      errors++;
      $display("FAIL rst_mid_recompute: got %0d/%0d upd=%b want 768/384 upd=1", gain_r, gain_b, gain_update);
    end
  endtask

  initial begin
    test_reset();
    test_ratio();
    test_unity();
    test_boundary();
    test_trunc();
    test_overrun();
    test_enable();
    test_rst_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
